// File: rtl/rst_seq_ctrl_if.sv
// Handshake bundle between the reset sequencer and the SPI subsystem blocks it controls.
// master = sequencer side, slave = downstream/software side.
interface rst_seq_ctrl_if #(
   parameter int NUM_DOM = 3
);
   logic               sw_rst_req;
   logic               sw_rst_ack;
   logic [NUM_DOM-1:0] dom_ready;
   logic [NUM_DOM-1:0] dom_rstn;
   logic               seq_busy;
   logic               seq_done;
   logic [NUM_DOM-1:0] dom_err;

   modport master (
      input  sw_rst_req,
      input  dom_ready,
      output sw_rst_ack,
      output dom_rstn,
      output seq_busy,
      output seq_done,
      output dom_err
   );

   modport slave (
      output sw_rst_req,
      output dom_ready,
      input  sw_rst_ack,
      input  dom_rstn,
      input  seq_busy,
      input  seq_done,
      input  dom_err
   );
endinterface

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer for the SPI clock domain: releases NUM_DOM resets in index order with ready handshakes.
// Optional RST_SEQ_ORDERED_ASSERT_EN: software reset drains domains in reverse order before re-asserting.
module rst_seq_ctrl #(
   parameter int NUM_DOM  = 3,
   parameter int HOLD_CYC = 16,
   parameter int STEP_CYC = 4,
   parameter int TMO_CYC  = 64,
   parameter int CNT_W    = 8
) (
   input logic            clk,
   input logic            rst,
   rst_seq_ctrl_if.master bus
);
   localparam int IDX_W = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1;

   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
   localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYC - 1);
   localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TMO_CYC - 1);
   localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DOM - 1);

`ifdef RST_SEQ_ORDERED_ASSERT_EN
   typedef enum logic [2:0] {
      ST_ASSERT   = 3'd0,
      ST_STEP     = 3'd1,
      ST_WAIT_RDY = 3'd2,
      ST_RUN      = 3'd3,
      ST_DRAIN    = 3'd4
   } state_t;
`else
   typedef enum logic [1:0] {
      ST_ASSERT   = 2'd0,
      ST_STEP     = 2'd1,
      ST_WAIT_RDY = 2'd2,
      ST_RUN      = 2'd3
   } state_t;
`endif

   state_t             state_r, state_s;
   logic [CNT_W-1:0]   cnt_r,   cnt_s;
   logic [IDX_W-1:0]   idx_r,   idx_s;
   logic [NUM_DOM-1:0] rstn_r,  rstn_s;
   logic [NUM_DOM-1:0] err_r,   err_s;
   logic               busy_r,  busy_s;
   logic               done_r,  done_s;
   logic               ack_r,   ack_s;

   // State and registered outputs; rst overrides every transition.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_ASSERT;
         cnt_r   <= '0;
         idx_r   <= '0;
         rstn_r  <= '0;
         err_r   <= '0;
         busy_r  <= 1'b1;
         done_r  <= 1'b0;
         ack_r   <= 1'b0;
      end else begin
         state_r <= state_s;
         cnt_r   <= cnt_s;
         idx_r   <= idx_s;
         rstn_r  <= rstn_s;
         err_r   <= err_s;
         busy_r  <= busy_s;
         done_r  <= done_s;
         ack_r   <= ack_s;
      end
   end

   // Next-state and next-output computation.
   always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      idx_s   = idx_r;
      rstn_s  = rstn_r;
      err_s   = err_r;
      busy_s  = busy_r;
      done_s  = done_r;
      ack_s   = 1'b0;

      case (state_r)
         ST_ASSERT: begin
            rstn_s = '0;
            busy_s = 1'b1;
            done_s = 1'b0;
            if (cnt_r == HOLD_LAST) begin
               state_s = ST_STEP;
               cnt_s   = '0;
            end else begin
               cnt_s = cnt_r + CNT_ONE;
            end
         end

         ST_STEP: begin
            if (cnt_r == STEP_LAST) begin
               rstn_s[idx_r] = 1'b1;
               state_s       = ST_WAIT_RDY;
               cnt_s         = '0;
            end else begin
               cnt_s = cnt_r + CNT_ONE;
            end
         end

         ST_WAIT_RDY: begin
            // Ready takes precedence over a timeout landing on the same cycle.
            if (bus.dom_ready[idx_r] || (cnt_r == TMO_LAST)) begin
               if (!bus.dom_ready[idx_r]) begin
                  err_s[idx_r] = 1'b1;
               end else begin
                  err_s = err_r;
               end
               cnt_s = '0;
               if (idx_r == IDX_LAST) begin
                  state_s = ST_RUN;
                  busy_s  = 1'b0;
                  done_s  = 1'b1;
               end else begin
                  idx_s   = idx_r + IDX_ONE;
                  state_s = ST_STEP;
               end
            end else begin
               cnt_s = cnt_r + CNT_ONE;
            end
         end

         ST_RUN: begin
            rstn_s = '1;
            busy_s = 1'b0;
            done_s = 1'b1;
            if (bus.sw_rst_req) begin
               ack_s  = 1'b1;
               err_s  = '0;
               cnt_s  = '0;
               busy_s = 1'b1;
               done_s = 1'b0;
`ifdef RST_SEQ_ORDERED_ASSERT_EN
               // Highest domain drops on the acceptance edge; idx tracks the next one to drop.
               rstn_s[IDX_LAST] = 1'b0;
               idx_s            = IDX_LAST - IDX_ONE;
               state_s          = ST_DRAIN;
`else
               rstn_s  = '0;
               idx_s   = '0;
               state_s = ST_ASSERT;
`endif
            end else begin
               state_s = ST_RUN;
            end
         end

`ifdef RST_SEQ_ORDERED_ASSERT_EN
         ST_DRAIN: begin
            busy_s = 1'b1;
            done_s = 1'b0;
            if (cnt_r == STEP_LAST) begin
               rstn_s[idx_r] = 1'b0;
               cnt_s         = '0;
               if (idx_r == '0) begin
                  state_s = ST_ASSERT;
               end else begin
                  idx_s = idx_r - IDX_ONE;
               end
            end else begin
               cnt_s = cnt_r + CNT_ONE;
            end
         end
`endif

         default: begin
            state_s = ST_ASSERT;
            cnt_s   = '0;
            idx_s   = '0;
            rstn_s  = '0;
            err_s   = '0;
            busy_s  = 1'b1;
            done_s  = 1'b0;
         end
      endcase
   end

   assign bus.dom_rstn   = rstn_r;
   assign bus.dom_err    = err_r;
   assign bus.seq_busy   = busy_r;
   assign bus.seq_done   = done_r;
   assign bus.sw_rst_ack = ack_r;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Directed self-checking bench for rst_seq_ctrl (NUM_DOM=3, default timing).
// Edge numbers in comments count from the first rising edge with rst low.
module tb_rst_seq_ctrl;
   logic clk;
   logic rst;
   int   n_cmp;
   int   n_bad;

   rst_seq_ctrl_if #(.NUM_DOM(3)) bus ();

   rst_seq_ctrl #(
      .NUM_DOM  (3),
      .HOLD_CYC (16),
      .STEP_CYC (4),
      .TMO_CYC  (64),
      .CNT_W    (8)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic wait_edges(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      wait_edges(3);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      bus.sw_rst_req = 1'b0;
      bus.dom_ready  = 3'b111;
      do_reset();
      n_cmp++; if (bus.dom_rstn !== 3'b000) begin n_bad++; $display("FAIL rst_rstn got %b exp 000", bus.dom_rstn); end
      n_cmp++; if (bus.seq_busy !== 1'b1) begin n_bad++; $display("FAIL rst_busy got %b exp 1", bus.seq_busy); end
      n_cmp++; if (bus.seq_done !== 1'b0) begin n_bad++; $display("FAIL rst_done got %b exp 0", bus.seq_done); end
      n_cmp++; if (bus.sw_rst_ack !== 1'b0) begin n_bad++; $display("FAIL rst_ack got %b exp 0", bus.sw_rst_ack); end
      n_cmp++; if (bus.dom_err !== 3'b000) begin n_bad++; $display("FAIL rst_err got %b exp 000", bus.dom_err); end
   endtask

   task automatic test_powerup();
      bus.dom_ready = 3'b111;
      do_reset();
      wait_edges(19); // edge 19
      n_cmp++; if (bus.dom_rstn !== 3'b000) begin n_bad++; $display("FAIL pu_e19 got %b exp 000", bus.dom_rstn); end
      wait_edges(1);  // edge 20
      n_cmp++; if (bus.dom_rstn !== 3'b001) begin n_bad++; $display("FAIL pu_e20 got %b exp 001", bus.dom_rstn); end
      wait_edges(4);  // edge 24
      n_cmp++; if (bus.dom_rstn !== 3'b001) begin n_bad++; $display("FAIL pu_e24 got %b exp 001", bus.dom_rstn); end
      wait_edges(1);  // edge 25
      n_cmp++; if (bus.dom_rstn !== 3'b011) begin n_bad++; $display("FAIL pu_e25 got %b exp 011", bus.dom_rstn); end
      wait_edges(4);  // edge 29
      n_cmp++; if (bus.dom_rstn !== 3'b011) begin n_bad++; $display("FAIL pu_e29 got %b exp 011", bus.dom_rstn); end
      wait_edges(1);  // edge 30
      n_cmp++; if (bus.dom_rstn !== 3'b111) begin n_bad++; $display("FAIL pu_e30 got %b exp 111", bus.dom_rstn); end
      n_cmp++; if (bus.seq_done !== 1'b0) begin n_bad++; $display("FAIL pu_done_e30 got %b exp 0", bus.seq_done); end
      wait_edges(1);  // edge 31
      n_cmp++; if (bus.seq_done !== 1'b1) begin n_bad++; $display("FAIL pu_done_e31 got %b exp 1", bus.seq_done); end
      n_cmp++; if (bus.seq_busy !== 1'b0) begin n_bad++; $display("FAIL pu_busy_e31 got %b exp 0", bus.seq_busy); end
      n_cmp++; if (bus.dom_err !== 3'b000) begin n_bad++; $display("FAIL pu_err got %b exp 000", bus.dom_err); end
   endtask

   task automatic test_slow_ready();
      bus.dom_ready = 3'b101;
      do_reset();
      wait_edges(35); // edge 35: dom 1 released at 25, still waiting
      n_cmp++; if (bus.dom_rstn !== 3'b011) begin n_bad++; $display("FAIL slow_e35 got %b exp 011", bus.dom_rstn); end
      bus.dom_ready = 3'b111;
      wait_edges(4);  // edge 39: handshake seen at 36
      n_cmp++; if (bus.dom_rstn !== 3'b011) begin n_bad++; $display("FAIL slow_e39 got %b exp 011", bus.dom_rstn); end
      wait_edges(1);  // edge 40
      n_cmp++; if (bus.dom_rstn !== 3'b111) begin n_bad++; $display("FAIL slow_e40 got %b exp 111", bus.dom_rstn); end
      wait_edges(1);  // edge 41
      n_cmp++; if (bus.seq_done !== 1'b1) begin n_bad++; $display("FAIL slow_done got %b exp 1", bus.seq_done); end
      n_cmp++; if (bus.dom_err !== 3'b000) begin n_bad++; $display("FAIL slow_err got %b exp 000", bus.dom_err); end
   endtask

   task automatic test_timeout();
      bus.dom_ready = 3'b101;
      do_reset();
      wait_edges(88); // edge 88: 63rd count in WAIT_RDY for dom 1
      n_cmp++; if (bus.dom_err !== 3'b000) begin n_bad++; $display("FAIL tmo_e88_err got %b exp 000", bus.dom_err); end
      n_cmp++; if (bus.dom_rstn !== 3'b011) begin n_bad++; $display("FAIL tmo_e88_rstn got %b exp 011", bus.dom_rstn); end
      wait_edges(1);  // edge 89
      n_cmp++; if (bus.dom_err !== 3'b010) begin n_bad++; $display("FAIL tmo_e89_err got %b exp 010", bus.dom_err); end
      wait_edges(4);  // edge 93
      n_cmp++; if (bus.dom_rstn !== 3'b111) begin n_bad++; $display("FAIL tmo_e93_rstn got %b exp 111", bus.dom_rstn); end
      wait_edges(1);  // edge 94
      n_cmp++; if (bus.seq_done !== 1'b1) begin n_bad++; $display("FAIL tmo_done got %b exp 1", bus.seq_done); end
      wait_edges(5);
      n_cmp++; if (bus.dom_err !== 3'b010) begin n_bad++; $display("FAIL tmo_err_sticky got %b exp 010", bus.dom_err); end
      n_cmp++; if (bus.seq_busy !== 1'b0) begin n_bad++; $display("FAIL tmo_busy got %b exp 0", bus.seq_busy); end
   endtask

   // Runs from RUN with dom_err=010 left over by test_timeout.
   task automatic test_sw_reset();
      bus.dom_ready  = 3'b111;
      bus.sw_rst_req = 1'b1;
      wait_edges(1);  // acceptance edge E
      n_cmp++; if (bus.sw_rst_ack !== 1'b1) begin n_bad++; $display("FAIL sw_ack got %b exp 1", bus.sw_rst_ack); end
      n_cmp++; if (bus.dom_rstn !== 3'b000) begin n_bad++; $display("FAIL sw_rstn got %b exp 000", bus.dom_rstn); end
      n_cmp++; if (bus.dom_err !== 3'b000) begin n_bad++; $display("FAIL sw_err got %b exp 000", bus.dom_err); end
      n_cmp++; if ({bus.seq_busy, bus.seq_done} !== 2'b10) begin n_bad++; $display("FAIL sw_busydone got %b exp 10", {bus.seq_busy, bus.seq_done}); end
      wait_edges(1);  // E+1, request still held
      n_cmp++; if (bus.sw_rst_ack !== 1'b0) begin n_bad++; $display("FAIL sw_ack_pulse got %b exp 0", bus.sw_rst_ack); end
      wait_edges(18); // E+19
      n_cmp++; if (bus.dom_rstn !== 3'b000) begin n_bad++; $display("FAIL sw_e19 got %b exp 000", bus.dom_rstn); end
      wait_edges(1);  // E+20
      n_cmp++; if (bus.dom_rstn !== 3'b001) begin n_bad++; $display("FAIL sw_e20 got %b exp 001", bus.dom_rstn); end
      wait_edges(10); // E+30
      n_cmp++; if (bus.dom_rstn !== 3'b111) begin n_bad++; $display("FAIL sw_e30 got %b exp 111", bus.dom_rstn); end
      wait_edges(1);  // E+31: first RUN cycle
      n_cmp++; if ({bus.seq_done, bus.sw_rst_ack} !== 2'b10) begin n_bad++; $display("FAIL sw_e31 done/ack got %b exp 10", {bus.seq_done, bus.sw_rst_ack}); end
      wait_edges(1);  // E+32: held request accepted again
      n_cmp++; if (bus.sw_rst_ack !== 1'b1) begin n_bad++; $display("FAIL sw_reack got %b exp 1", bus.sw_rst_ack); end
      n_cmp++; if (bus.dom_rstn !== 3'b000) begin n_bad++; $display("FAIL sw_reack_rstn got %b exp 000", bus.dom_rstn); end
      bus.sw_rst_req = 1'b0;
   endtask

   task automatic test_mid_seq_and_rst();
      bus.dom_ready  = 3'b111;
      bus.sw_rst_req = 1'b0;
      do_reset();
      wait_edges(22); // edge 22: STEP for idx 1
      bus.sw_rst_req = 1'b1;
      for (int e = 23; e <= 31; e++) begin
         wait_edges(1);
         n_cmp++; if (bus.sw_rst_ack !== 1'b0) begin n_bad++; $display("FAIL mid_noack e%0d got %b exp 0", e, bus.sw_rst_ack); end
      end
      n_cmp++; if (bus.seq_done !== 1'b1) begin n_bad++; $display("FAIL mid_done_e31 got %b exp 1", bus.seq_done); end
      wait_edges(1);  // edge 32
      n_cmp++; if (bus.sw_rst_ack !== 1'b1) begin n_bad++; $display("FAIL mid_ack_e32 got %b exp 1", bus.sw_rst_ack); end
      bus.sw_rst_req = 1'b0;
      bus.dom_ready  = 3'b000;
      wait_edges(20); // edge 52: dom 0 released, waiting on a ready that never comes
      n_cmp++; if (bus.dom_rstn !== 3'b001) begin n_bad++; $display("FAIL mid_e52 got %b exp 001", bus.dom_rstn); end
      wait_edges(3);
      rst = 1'b1;
      wait_edges(1);
      n_cmp++; if (bus.dom_rstn !== 3'b000) begin n_bad++; $display("FAIL midrst_rstn got %b exp 000", bus.dom_rstn); end
      n_cmp++; if ({bus.seq_busy, bus.seq_done, bus.sw_rst_ack} !== 3'b100) begin n_bad++; $display("FAIL midrst_flags got %b exp 100", {bus.seq_busy, bus.seq_done, bus.sw_rst_ack}); end
      rst = 1'b0;
   endtask

`ifdef RST_SEQ_ORDERED_ASSERT_EN
   task automatic test_drain();
      bus.dom_ready  = 3'b111;
      bus.sw_rst_req = 1'b0;
      do_reset();
      wait_edges(31);
      bus.sw_rst_req = 1'b1;
      wait_edges(1);  // acceptance edge A
      bus.sw_rst_req = 1'b0;
      n_cmp++; if (bus.dom_rstn !== 3'b011) begin n_bad++; $display("FAIL drain_a0 got %b exp 011", bus.dom_rstn); end
      wait_edges(3);
      n_cmp++; if (bus.dom_rstn !== 3'b011) begin n_bad++; $display("FAIL drain_a3 got %b exp 011", bus.dom_rstn); end
      wait_edges(1);
      n_cmp++; if (bus.dom_rstn !== 3'b001) begin n_bad++; $display("FAIL drain_a4 got %b exp 001", bus.dom_rstn); end
      wait_edges(4);
      n_cmp++; if (bus.dom_rstn !== 3'b000) begin n_bad++; $display("FAIL drain_a8 got %b exp 000", bus.dom_rstn); end
      n_cmp++; if (bus.seq_busy !== 1'b1) begin n_bad++; $display("FAIL drain_busy got %b exp 1", bus.seq_busy); end
      wait_edges(19);
      n_cmp++; if (bus.dom_rstn !== 3'b000) begin n_bad++; $display("FAIL drain_a27 got %b exp 000", bus.dom_rstn); end
      wait_edges(1);
      n_cmp++; if (bus.dom_rstn !== 3'b001) begin n_bad++; $display("FAIL drain_a28 got %b exp 001", bus.dom_rstn); end
   endtask
`endif

   initial begin
      n_cmp          = 0;
      n_bad          = 0;
      rst            = 1'b1;
      bus.sw_rst_req = 1'b0;
      bus.dom_ready  = 3'b111;
      test_reset();
      test_powerup();
      test_slow_ready();
      test_timeout();
`ifdef RST_SEQ_ORDERED_ASSERT_EN
      test_drain();
`else
      test_sw_reset();
`endif
      test_mid_seq_and_rst();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
